alu_writeback: RTL

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback_pkg.sv | 15 +
 rtl/wb_addr_fifo.sv | 49 ++++
 rtl/alu_writeback.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_writeback_pkg.sv
// Shared defaults and FSM state type for the ALU writeback slice.
package alu_writeback_pkg;

  localparam int unsigned DEF_CORES      = 32;
  localparam int unsigned DEF_BITS       = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_addr_fifo.sv
// Pending-destination FIFO; DEPTH must be a power of two so pointers wrap naturally.
module wb_addr_fifo #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count,
  output logic                  full
);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop_ok)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push_ok, pop_ok})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_writeback.sv
// Gathers per-lane ALU results into one vector and writes it to the destination
// popped from the pending FIFO once every lane has reported.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int unsigned CORES      = DEF_CORES,
  parameter int unsigned BITS       = DEF_BITS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [ADDR_WIDTH-1:0]   issue_addr,
  output logic                    issue_ready,
  input  logic [CORES*BITS-1:0]   alu_out,
  input  logic [CORES-1:0]        is_output_valid,
  output logic                    write,
  output logic [ADDR_WIDTH-1:0]   write_addr,
  output logic [CORES*BITS-1:0]   write_data,
  output logic                    busy,
  output logic                    overflow_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_state_t              state, state_nxt;
  logic [CORES-1:0]       mask;
  logic [CORES-1:0]       merged;
  logic [CORES-1:0]       cap;
  logic [CORES*BITS-1:0]  lane_buf;
  logic [CORES*BITS-1:0]  merged_buf;
  logic [ADDR_WIDTH-1:0]  fifo_head;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   capture_en;
  logic                   complete;
  logic                   dup;

  wb_addr_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (issue_valid),
    .pop   (complete),
    .din   (issue_addr),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  assign issue_ready = !fifo_full;

  // In HOLD nothing is captured; every valid bit counts as a duplicate.
  assign cap      = is_output_valid & ~mask & {CORES{capture_en}};
  assign dup      = |(is_output_valid & (mask | {CORES{~capture_en}}));
  assign merged   = mask | is_output_valid;
  assign complete = (&merged) && (fifo_count != '0);

  always_comb begin
    merged_buf = lane_buf;
    for (int unsigned i = 0; i < CORES; i++) begin
      if (cap[i]) merged_buf[i*BITS +: BITS] = alu_out[i*BITS +: BITS];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (complete)      state_nxt = IDLE;
    else if (&merged)  state_nxt = HOLD;
    else if (|merged)  state_nxt = COLLECT;
    else               state_nxt = IDLE;
  end

  always_comb begin
    busy       = (state != IDLE) || (fifo_count != '0);
    capture_en = (state != HOLD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mask         <= '0;
      lane_buf     <= '0;
      write        <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      overflow_err <= 1'b0;
    end else begin
      write <= complete;
      if (complete) begin
        write_data <= merged_buf;
        write_addr <= fifo_head;
        mask       <= '0;
        lane_buf   <= '0;
      end else begin
        mask     <= mask | cap;
        lane_buf <= merged_buf;
      end
      if (dup) overflow_err <= 1'b1;
    end
  end

endmodule
